// File: rtl/addr8s_inv_serial.sv
// Bit-serial operand recovery: recomputes B = S - A LSB-first over ten steps
// with one full adder and a registered carry, flagging results outside int8.
module addr8s_inv_serial (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a_in,
    input  logic [8:0] s_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] b_out,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_q, state_d;
    logic [8:0]  s_sh_q;
    logic [7:0]  a_sh_q;
    logic [3:0]  cnt_q;
    logic        carry_q;
    logic [9:0]  d_q;
    logic [7:0]  b_out_q;
    logic        err_q;
    logic        out_valid_q;

    logic        s_bit, a_bit, sum_bit, carry_d;
    logic [9:0]  d_d;
    logic        accept, last_step;

    // Subtraction as S + ~A + 1: the +1 enters through the carry preset on accept.
    assign s_bit     = s_sh_q[0];
    assign a_bit     = ~a_sh_q[0];
    assign sum_bit   = s_bit ^ a_bit ^ carry_q;
    assign carry_d   = (s_bit & a_bit) | (carry_q & (s_bit ^ a_bit));
    assign d_d       = {sum_bit, d_q[9:1]};
    assign accept    = in_ready & in_valid;
    assign last_step = (state_q == SHIFT) && (cnt_q == 4'd9);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = SHIFT;
            SHIFT:   if (last_step) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == IDLE);
    end

    // Operand shifters refill with their sign bit, so steps past the MSB reuse it.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_sh_q      <= '0;
            a_sh_q      <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            d_q         <= '0;
            b_out_q     <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                s_sh_q  <= s_in;
                a_sh_q  <= a_in;
                cnt_q   <= '0;
                carry_q <= 1'b1;
                d_q     <= '0;
            end else if (state_q == SHIFT) begin
                s_sh_q  <= {s_sh_q[8], s_sh_q[8:1]};
                a_sh_q  <= {a_sh_q[7], a_sh_q[7:1]};
                cnt_q   <= cnt_q + 4'd1;
                carry_q <= carry_d;
                d_q     <= d_d;
            end
            if (last_step) begin
                b_out_q     <= d_d[7:0];
                err_q       <= ~((d_d[9] == d_d[8]) & (d_d[8] == d_d[7]));
                out_valid_q <= 1'b1;
            end else if ((state_q == DONE) && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign b_out     = b_out_q;
    assign err       = err_q;

endmodule

// File: tb/tb_addr8s_inv_serial.sv
// Randomised self-checking bench for addr8s_inv_serial against a
// transaction-level model of D = S - A with cycle-accurate handshake timing.
module tb_addr8s_inv_serial;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a_in;
    logic [8:0] s_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] b_out;
    logic       err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit       m_idle  = 1'b1;
    bit       m_valid = 1'b0;
    bit [7:0] m_b     = 8'h00;
    bit       m_err   = 1'b0;
    int       m_left  = 0;
    int       m_d     = 0;
    bit       m_live  = 1'b0;

    always #5 clk = ~clk;

    addr8s_inv_serial dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .s_in      (s_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .b_out     (b_out),
        .err       (err)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the result is plain integer subtraction; err is a range test.
    always @(posedge clk) begin
        if (rst) begin
            m_idle = 1'b1; m_valid = 1'b0; m_b = 8'h00; m_err = 1'b0; m_left = 0;
        end else if (m_idle) begin
            if (in_valid) begin
                m_idle = 1'b0;
                m_left = 10;
                m_d    = int'($signed(s_in)) - int'($signed(a_in));
            end
        end else if (!m_valid) begin
            m_left--;
            if (m_left == 0) begin
                m_valid = 1'b1;
                m_b     = m_d[7:0];
                m_err   = (m_d < -128) || (m_d > 127);
            end
        end else if (out_ready) begin
            m_valid = 1'b0;
            m_idle  = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("in_ready",  int'(in_ready),  int'(m_idle));
            check("out_valid", int'(out_valid), int'(m_valid));
            check("b_out",     int'(b_out),     int'(m_b));
            check("err",       int'(err),       int'(m_err));
        end
    end

    task automatic junk();
        in_valid = 1'($urandom_range(0, 1));
        a_in     = 8'($urandom);
        s_in     = 9'($urandom);
    endtask

    // One transaction; literal expectations checked when lit is set.
    task automatic txn(input logic [7:0] a, input logic [8:0] s, input bit lit,
                       input logic [7:0] eb, input logic ee, input int hold);
        int cyc;
        @(posedge clk); #1;
        in_valid = 1'b1; a_in = a; s_in = s; out_ready = 1'b0;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            junk();
            cyc++;
        end while (!out_valid && cyc <= 30);
        if (cyc > 30) begin
            checks++; errors++;
            $display("FAIL timeout: out_valid never rose, a=0x%0h s=0x%0h", a, s);
        end else if (lit) begin
            check("latency", cyc, 11);
            check("lit_b",   int'(b_out), int'(eb));
            check("lit_err", int'(err),   int'(ee));
        end
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            junk();
        end
        out_ready = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        if (lit) check("exit_in_ready", int'(in_ready), 1);
    endtask

    initial begin
        logic [7:0] a, b;
        logic [8:0] s;
        rst = 1'b1; in_valid = 1'b0; a_in = '0; s_in = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_live = 1'b1;
        check("rst_in_ready",  int'(in_ready),  1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_b_out",     int'(b_out),     0);
        check("rst_err",       int'(err),       0);

        txn(8'h64, 9'h07F, 1'b1, 8'h1B, 1'b0, 0);
        txn(8'h80, 9'h100, 1'b1, 8'h80, 1'b0, 1);
        txn(8'h7F, 9'h0FE, 1'b1, 8'h7F, 1'b0, 2);
        txn(8'h7F, 9'h100, 1'b1, 8'h81, 1'b1, 0);
        txn(8'hFF, 9'h0FF, 1'b1, 8'h00, 1'b1, 5);

        // Reset while step 4 is processing, with out_ready/in_valid also high.
        @(posedge clk); #1;
        in_valid = 1'b1; a_in = 8'h12; s_in = 9'h034;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("midrst_in_ready",  int'(in_ready),  1);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_b_out",     int'(b_out),     0);
        check("midrst_err",       int'(err),       0);
        txn(8'h05, 9'h003, 1'b1, 8'hFE, 1'b0, 0);

        // Legal pairs: S = A + B must give back B without error.
        for (int i = 0; i < 3000; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            s = 9'(int'($signed(a)) + int'($signed(b)));
            txn(a, s, 1'b1, b, 1'b0, $urandom_range(0, 2));
        end
        // Arbitrary S: the per-cycle model covers b_out and the range flag.
        for (int i = 0; i < 2000; i++) begin
            txn(8'($urandom), 9'($urandom), 1'b0, 8'h00, 1'b0, $urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
